// File: rtl/seqgen_pkg.sv
// Shared types and constants for the traffic phase sequencer.
package seqgen_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      GREEN  = 2'b01,
      YELLOW = 2'b10,
      CLEAR  = 2'b11
   } phase_e;

endpackage

// File: rtl/seqgen_phase_timer.sv
// Loadable in-phase up-counter; done flags the last cycle of the current dwell.
module seqgen_phase_timer
   import seqgen_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] dwell,
   input  logic             load,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   // Terminal count: the counter never runs past dwell-1, so no wrap handling.
   assign done = (count == (dwell - CNT_W'(1)));

   // Count up each cycle; a phase change restarts from 0 on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/traffic_sequence_generator.sv
// Free-running RED -> GREEN -> YELLOW phase sequencer with parameterised dwells.
// Optional all-red clearance phase after YELLOW when SEQGEN_ALL_RED_EN is defined.
module traffic_sequence_generator
   import seqgen_pkg::*;
#(
   parameter logic [CNT_W-1:0] RED_CYCLES    = 40000,
   parameter logic [CNT_W-1:0] GREEN_CYCLES  = 35000,
   parameter logic [CNT_W-1:0] YELLOW_CYCLES = 5000,
   parameter logic [CNT_W-1:0] CLEAR_CYCLES  = 2000
)
(
   input  logic             clk,
   input  logic             reset,
   output logic [1:0]       out,
   output logic [CNT_W-1:0] counter
);

   // A zero dwell would never reach its terminal count; reject at elaboration.
   // CLEAR_CYCLES is validated in every build so toggling the macro is safe.
   if (RED_CYCLES == 0) begin : g_bad_red
      $error("RED_CYCLES must be at least 1");
   end
   if (GREEN_CYCLES == 0) begin : g_bad_green
      $error("GREEN_CYCLES must be at least 1");
   end
   if (YELLOW_CYCLES == 0) begin : g_bad_yellow
      $error("YELLOW_CYCLES must be at least 1");
   end
   if (CLEAR_CYCLES == 0) begin : g_bad_clear
      $error("CLEAR_CYCLES must be at least 1");
   end

   phase_e           state;
   phase_e           state_next;
   logic [CNT_W-1:0] dwell;
   logic             load;
   logic             done;

   seqgen_phase_timer u_timer (
      .clk   (clk),
      .reset (reset),
      .dwell (dwell),
      .load  (load),
      .count (counter),
      .done  (done)
   );

   // Phase register; reset forces RED immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RED;
      end else begin
         state <= state_next;
      end
   end

   // Select the dwell for the current phase and advance on terminal count.
   always_comb begin
      state_next = state;
      dwell      = RED_CYCLES;
      load       = done;
      case (state)
         RED: begin
            dwell = RED_CYCLES;
            if (done) state_next = GREEN;
         end
         GREEN: begin
            dwell = GREEN_CYCLES;
            if (done) state_next = YELLOW;
         end
         YELLOW: begin
            dwell = YELLOW_CYCLES;
`ifdef SEQGEN_ALL_RED_EN
            if (done) state_next = CLEAR;
`else
            if (done) state_next = RED;
`endif
         end
         CLEAR: begin
`ifdef SEQGEN_ALL_RED_EN
            dwell = CLEAR_CYCLES;
            if (done) state_next = RED;
`else
            // Unreachable code in this build: recover straight to RED, counter 0.
            load       = 1'b1;
            state_next = RED;
`endif
         end
      endcase
   end

   assign out = state;

endmodule

// File: tb/tb_traffic_sequence_generator.sv
module tb_traffic_sequence_generator;

`ifdef SEQGEN_ALL_RED_EN
   localparam int P  = 11;
   localparam int P1 = 4;
`else
   localparam int P  = 9;
   localparam int P1 = 3;
`endif

   logic        clk;
   logic        reset;
   logic [1:0]  out;
   logic [31:0] counter;
   logic [1:0]  out1;
   logic [31:0] counter1;

   int checks   = 0;
   int failures = 0;

   int exp_out [11];
   int exp_cnt [11];

   traffic_sequence_generator #(
      .RED_CYCLES    (32'd4),
      .GREEN_CYCLES  (32'd3),
      .YELLOW_CYCLES (32'd2),
      .CLEAR_CYCLES  (32'd2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .out     (out),
      .counter (counter)
   );

   traffic_sequence_generator #(
      .RED_CYCLES    (32'd1),
      .GREEN_CYCLES  (32'd1),
      .YELLOW_CYCLES (32'd1),
      .CLEAR_CYCLES  (32'd1)
   ) dut1 (
      .clk     (clk),
      .reset   (reset),
      .out     (out1),
      .counter (counter1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out"}, {30'd0, out}, 32'd0);
      check({tag, "_cnt"}, counter, 32'd0);
      check({tag, "_out1"}, {30'd0, out1}, 32'd0);
      check({tag, "_cnt1"}, counter1, 32'd0);
   endtask

   initial begin
      // Hand-computed sequence for RED=4, GREEN=3, YELLOW=2 (CLEAR=2 with the macro).
      exp_out = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 3};
      exp_cnt = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0, 1};

      // Reset asserted at time 0: outputs settle before any clock edge.
      reset = 1'b0;
      #1;
      check_reset_state("rst_async");
      for (int i = 0; i < 10; i++) begin
         tick();
         check_reset_state("rst_hold");
      end

      // Release mid-cycle; nothing changes until the next rising edge.
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_state("rel_pre_edge");

      // Two full periods of the nominal sequence and of the all-ones dwell case.
      for (int i = 0; i < 2 * P; i++) begin
         check($sformatf("seq_out_%0d", i), {30'd0, out}, 32'(exp_out[i % P]));
         check($sformatf("seq_cnt_%0d", i), counter, 32'(exp_cnt[i % P]));
         check($sformatf("one_out_%0d", i), {30'd0, out1}, 32'(i % P1));
         check($sformatf("one_cnt_%0d", i), counter1, 32'd0);
         tick();
      end

      // Restart cleanly, run into GREEN with counter 1, then reset between edges.
      reset = 1'b0;
      #1;
      check_reset_state("rst_restart");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("mid_green_out", {30'd0, out}, 32'd1);
      check("mid_green_cnt", counter, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("rst_mid_green");
      tick();
      check_reset_state("rst_mid_green_hold");

      // After release the full 4-cycle RED runs before GREEN.
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rerun_out_%0d", i), {30'd0, out}, 32'(exp_out[i]));
         check($sformatf("rerun_cnt_%0d", i), counter, 32'(exp_cnt[i]));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
